// File: rtl/axil_memory.sv
// AXI4-Lite slave backed by a word-addressed RAM with a write-protected ROM window.
// Read and write channels run as independent FSMs over the same storage.
module axil_memory #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ROM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
    localparam logic [31:0] ROM_W   = 32'(ROM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_e;

    logic [31:0] mem_q [DEPTH_WORDS];

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;

    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [1:0]  rresp_d;
    logic [31:0] r_off, r_idx;
    logic        r_in;
    logic        ar_fire;

    logic        aw_have_q, w_have_q;
    logic [31:0] awaddr_q;
    logic [2:0]  awprot_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic [1:0]  wresp_d;

    logic        aw_fire, w_fire, wr_done;
    logic [31:0] waddr_e, wdata_e;
    logic [2:0]  wprot_e;
    logic [3:0]  wstrb_e;
    logic [31:0] w_off, w_idx;
    logic        w_in;

    logic        unused_bits;

    assign unused_bits = &{1'b0, r_off[1:0], r_idx[31:AW], w_off[1:0],
                           w_idx[31:AW], arprot[1:0], wprot_e[1:0]};

    // Read address decode: range, alignment, then fetch-outside-ROM check.
    always_comb begin
        r_off   = araddr - BASE_ADDR;
        r_idx   = {2'b00, r_off[31:2]};
        r_in    = (araddr >= BASE_ADDR) && (r_idx < DEPTH_W);
        rresp_d = RESP_OKAY;
        if (!r_in) begin
            rresp_d = RESP_DECERR;
        end else if (araddr[1:0] != 2'b00) begin
            rresp_d = RESP_SLVERR;
        end else if (arprot[2] && (r_idx >= ROM_W)) begin
            rresp_d = RESP_SLVERR;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_state_d = r_state_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    assign ar_fire = arvalid && arready;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // Capture read data and status at the AR handshake; memory reads
    // see pre-write contents when a write commits on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= 32'h0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rresp_q <= rresp_d;
            if (rresp_d == RESP_OKAY) begin
                rdata_q <= mem_q[r_idx[AW-1:0]];
            end else begin
                rdata_q <= 32'h0;
            end
        end
    end

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign wr_done = (aw_have_q || aw_fire) && (w_have_q || w_fire);

    assign waddr_e = aw_have_q ? awaddr_q : awaddr;
    assign wprot_e = aw_have_q ? awprot_q : awprot;
    assign wdata_e = w_have_q ? wdata_q : wdata;
    assign wstrb_e = w_have_q ? wstrb_q : wstrb;

    // Write address decode: range, alignment, then ROM/instruction guard.
    always_comb begin
        w_off   = waddr_e - BASE_ADDR;
        w_idx   = {2'b00, w_off[31:2]};
        w_in    = (waddr_e >= BASE_ADDR) && (w_idx < DEPTH_W);
        wresp_d = RESP_OKAY;
        if (!w_in) begin
            wresp_d = RESP_DECERR;
        end else if (waddr_e[1:0] != 2'b00) begin
            wresp_d = RESP_SLVERR;
        end else if (wprot_e[2] || (w_idx < ROM_W)) begin
            wresp_d = RESP_SLVERR;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_state_d = w_state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) begin
                    w_state_d = W_RESP;
                end else if (awvalid || wvalid) begin
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                awready = !aw_have_q;
                wready  = !w_have_q;
                if ((aw_have_q || awvalid) && (w_have_q || wvalid)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    assign bresp = bresp_q;

    // Latch each write channel at its own handshake; settle status on the second.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= 32'h0;
            awprot_q  <= 3'b000;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            bresp_q   <= RESP_OKAY;
        end else if (wr_done) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            bresp_q   <= wresp_d;
        end else begin
            if (aw_fire) begin
                aw_have_q <= 1'b1;
                awaddr_q  <= awaddr;
                awprot_q  <= awprot;
            end
            if (w_fire) begin
                w_have_q <= 1'b1;
                wdata_q  <= wdata;
                wstrb_q  <= wstrb;
            end
        end
    end

    // Commit strobed bytes of an accepted write; storage is never reset.
    always_ff @(posedge clk) begin
        if (reset && wr_done && (wresp_d == RESP_OKAY)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_e[b]) begin
                    mem_q[w_idx[AW-1:0]][8*b +: 8] <= wdata_e[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_memory.sv
// Directed bench for axil_memory: handshakes, decode errors, ROM guard,
// read-first collision, read backpressure and reset behaviour.
module tb_axil_memory;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic        clk;
    logic        reset;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int tests_run;
    int tests_failed;

    axil_memory #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .ROM_WORDS  (256)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .awprot (awprot),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .arprot (arprot),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // gap > 0: AW first, W gap edges later; 0: same cycle; < 0: W first.
    task automatic wr(input logic [31:0] a, input logic [2:0] p,
                      input logic [31:0] d, input logic [3:0] s,
                      input int gap, output logic [1:0] resp);
        int n;
        if (gap < 0) begin
            wvalid = 1'b1; wdata = d; wstrb = s;
            tick;
            wvalid = 1'b0;
            chk("wfirst_awready", awready, 1);
            chk("wfirst_wready", wready, 0);
            awvalid = 1'b1; awaddr = a; awprot = p;
            tick;
            awvalid = 1'b0;
        end else begin
            awvalid = 1'b1; awaddr = a; awprot = p;
            if (gap == 0) begin
                wvalid = 1'b1; wdata = d; wstrb = s;
            end
            tick;
            awvalid = 1'b0;
            wvalid  = 1'b0;
            if (gap > 0) begin
                chk("awfirst_awready", awready, 0);
                chk("awfirst_wready", wready, 1);
                repeat (gap - 1) tick;
                wvalid = 1'b1; wdata = d; wstrb = s;
                tick;
                wvalid = 1'b0;
            end
        end
        n = 0;
        while (!bvalid && n < 8) begin
            tick;
            n++;
        end
        chk("bvalid_seen", bvalid, 1);
        resp = bresp;
        bready = 1'b1;
        tick;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] p,
                      output logic [31:0] d, output logic [1:0] resp);
        arvalid = 1'b1; araddr = a; arprot = p;
        tick;
        arvalid = 1'b0;
        chk("rvalid_lat1", rvalid, 1);
        d    = rdata;
        resp = rresp;
        rready = 1'b1;
        tick;
        rready = 1'b0;
        chk("arready_after_r", arready, 1);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] rom_v;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        awvalid = 1'b0; awaddr = 32'h0; awprot = 3'b000;
        wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = 32'h0; arprot = 3'b000;
        rready = 1'b0;

        tick;
        tick;
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b1;
        tick;

        wr(BASE + 32'h400, 3'b000, 32'hDEADBEEF, 4'hF, 2, r);
        chk("w400_resp", r, OKAY);
        rd(BASE + 32'h400, 3'b000, d, r);
        chk("r400_data", d, 32'hDEADBEEF);
        chk("r400_resp", r, OKAY);

        wr(BASE + 32'h400, 3'b000, 32'h0000_0011, 4'b0001, 0, r);
        chk("w400b_resp", r, OKAY);
        rd(BASE + 32'h400, 3'b000, d, r);
        chk("r400b_data", d, 32'hDEADBE11);

        wr(BASE + 32'h404, 3'b000, 32'h1234_5678, 4'hF, -1, r);
        chk("w404_resp", r, OKAY);
        wr(BASE + 32'h404, 3'b000, 32'hAABB_CCDD, 4'b0110, 0, r);
        chk("w404b_resp", r, OKAY);
        wr(BASE + 32'h404, 3'b000, 32'hFFFF_FFFF, 4'b0000, 1, r);
        chk("w404_nostrb_resp", r, OKAY);
        rd(BASE + 32'h404, 3'b000, d, r);
        chk("r404_data", d, 32'h12BB_CC78);

        rd(BASE + 4 * DEPTH, 3'b000, d, r);
        chk("r_top_resp", r, DECERR);
        chk("r_top_data", d, 0);
        rd(BASE + 32'h402, 3'b000, d, r);
        chk("r_mis_resp", r, SLVERR);
        chk("r_mis_data", d, 0);
        rd(BASE - 4, 3'b000, d, r);
        chk("r_below_resp", r, DECERR);
        rd(BASE + 4 * DEPTH - 4, 3'b000, d, r);
        chk("r_last_resp", r, OKAY);
        rd(BASE + 4 * DEPTH - 2, 3'b000, d, r);
        chk("r_last_mis_resp", r, SLVERR);

        wr(BASE + 32'h400, 3'b101, 32'h0, 4'hF, 0, r);
        chk("w_iprot_resp", r, SLVERR);
        rd(BASE + 32'h400, 3'b000, d, r);
        chk("r_iprot_data", d, 32'hDEADBE11);

        rd(BASE + 32'h10, 3'b000, rom_v, r);
        chk("r_rom_resp", r, OKAY);
        wr(BASE + 32'h10, 3'b000, ~rom_v, 4'hF, 0, r);
        chk("w_rom_resp", r, SLVERR);
        rd(BASE + 32'h10, 3'b000, d, r);
        chk("r_rom_kept", d, rom_v);
        wr(BASE + 32'h3FC, 3'b000, 32'h0, 4'hF, 0, r);
        chk("w_rom_last_resp", r, SLVERR);
        wr(BASE + 32'h401, 3'b000, 32'h0, 4'hF, 0, r);
        chk("w_mis_resp", r, SLVERR);
        wr(BASE + 4 * DEPTH, 3'b000, 32'h0, 4'hF, 0, r);
        chk("w_top_resp", r, DECERR);
        rd(BASE + 32'h400, 3'b000, d, r);
        chk("r_after_errs", d, 32'hDEADBE11);

        rd(BASE + 32'h400, 3'b100, d, r);
        chk("r_ifetch_ram_resp", r, SLVERR);
        chk("r_ifetch_ram_data", d, 0);
        rd(BASE + 32'h10, 3'b100, d, r);
        chk("r_ifetch_rom_resp", r, OKAY);
        chk("r_ifetch_rom_data", d, rom_v);

        awvalid = 1'b1; awaddr = BASE + 32'h400; awprot = 3'b000;
        tick;
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        arvalid = 1'b1; araddr = BASE + 32'h400; arprot = 3'b000;
        tick;
        wvalid = 1'b0;
        arvalid = 1'b0;
        chk("rf_rvalid", rvalid, 1);
        chk("rf_rdata", rdata, 32'hDEADBE11);
        chk("rf_bvalid", bvalid, 1);
        chk("rf_bresp", bresp, OKAY);
        rready = 1'b1;
        bready = 1'b1;
        tick;
        rready = 1'b0;
        bready = 1'b0;
        rd(BASE + 32'h400, 3'b000, d, r);
        chk("rf_after", d, 32'hCAFE_F00D);

        arvalid = 1'b1; araddr = BASE + 32'h400; arprot = 3'b000;
        tick;
        araddr = BASE + 32'h404;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", rvalid, 1);
            chk("stall_rdata", rdata, 32'hCAFE_F00D);
            chk("stall_arready", arready, 0);
            tick;
        end
        arvalid = 1'b0;
        reset = 1'b0;
        tick;
        chk("rstmid_rvalid", rvalid, 0);
        chk("rstmid_arready", arready, 1);
        chk("rstmid_rdata", rdata, 0);
        reset = 1'b1;
        tick;
        rd(BASE + 32'h400, 3'b000, d, r);
        chk("mem_kept_rst", d, 32'hCAFE_F00D);

        awvalid = 1'b1; awaddr = BASE + 32'h404; awprot = 3'b000;
        tick;
        awvalid = 1'b0;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("wdrop_awready", awready, 1);
        chk("wdrop_wready", wready, 1);
        chk("wdrop_bvalid", bvalid, 0);
        wvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF;
        tick;
        wvalid = 1'b0;
        chk("wdrop_no_b", bvalid, 0);
        awvalid = 1'b1; awaddr = BASE + 32'h10; awprot = 3'b000;
        tick;
        awvalid = 1'b0;
        chk("wdrop_b", bvalid, 1);
        chk("wdrop_bresp", bresp, SLVERR);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        rd(BASE + 32'h404, 3'b000, d, r);
        chk("wdrop_mem", d, 32'h12BB_CC78);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axil_memory.md
AXIL_MEMORY -- requirements
Module: axil_memory
Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words backing the slave.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (word-aligned).
REQ-003 SHALL have parameter ROM_WORDS, default 256, words from BASE_ADDR that are write-protected.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port awvalid  input  1  write address valid.
REQ-007 SHALL have port awready  output  1  write address accepted.
REQ-008 SHALL have port awaddr  input  32  write byte address.
REQ-009 SHALL have port awprot  input  3  write protection (bit 2 = instruction access).
REQ-010 SHALL have port wvalid  input  1  write data valid.
REQ-011 SHALL have port wready  output  1  write data accepted.
REQ-012 SHALL have port wdata  input  32  write data.
REQ-013 SHALL have port wstrb  input  4  byte enables, bit n -> wdata[8n+7:8n].
REQ-014 SHALL have port bvalid  output  1  write response valid.
REQ-015 SHALL have port bready  input  1  master accepts write response.
REQ-016 SHALL have port bresp  output  2  write status.
REQ-017 SHALL have port arvalid  input  1  read address valid.
REQ-018 SHALL have port arready  output  1  read address accepted.
REQ-019 SHALL have port araddr  input  32  read byte address.
REQ-020 SHALL have port arprot  input  3  read protection (bit 2 = instruction fetch).
REQ-021 SHALL have port rvalid  output  1  read data valid.
REQ-022 SHALL have port rready  input  1  master accepts read data.
REQ-023 SHALL have port rdata  output  32  read data.
REQ-024 SHALL have port rresp  output  2  read status.
Function
REQ-025 SHALL encode responses OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11; EXOKAY never issued.
REQ-026 SHALL run read and write channels as independent FSMs; neither stalls the other.
REQ-027 Read FSM SHALL have states R_IDLE (arready=1), R_RESP (rvalid=1, arready=0); AR handshake in R_IDLE -> R_RESP; rvalid&&rready in R_RESP -> R_IDLE.
REQ-028 Read latency SHALL be 1: AR handshake at edge N -> rvalid, rdata, rresp valid from edge N, held stable until the rready handshake.
REQ-029 Write FSM SHALL have W_IDLE (awready=wready=1), W_WAIT (one of AW/W captured; only the missing channel's ready=1), W_RESP (bvalid=1, both readies 0).
REQ-030 AW and W SHALL be accepted in either order or the same cycle; address, prot, data, strobes latched at their own handshake.
REQ-031 At the edge completing the second handshake, the write SHALL commit (only strobed bytes of an OKAY access) and FSM -> W_RESP; bvalid&&bready -> W_IDLE.
REQ-032 Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL give DECERR, no memory access, rdata=0.
REQ-033 Address with addr[1:0]!=0 SHALL give SLVERR, no access, rdata=0; DECERR takes priority.
REQ-034 Write to word index < ROM_WORDS, or any write with awprot[2]=1, SHALL give SLVERR and leave memory unchanged.
REQ-035 wstrb=4'b0000 on a valid address SHALL give OKAY and change nothing.
REQ-036 Read and write to the same word committing on the same edge SHALL return pre-write data (read-first).
REQ-037 Reads SHALL ignore arprot except that arprot[2]=1 outside the ROM region gives SLVERR.
Reset
REQ-038 When reset=0 at an edge: both FSMs idle, awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, pending transactions dropped; memory contents unchanged.
Verification
REQ-039 Write 32'hDEADBEEF, wstrb 4'hF to BASE+0x400 (AW then W two cycles later) -> bresp OKAY; read -> rdata 32'hDEADBEEF, rvalid one edge after AR.
REQ-040 Then write 32'h0000_0011, wstrb 4'b0001 to BASE+0x400 -> read 32'hDEADBE11.
REQ-041 Read BASE+4*DEPTH_WORDS -> rresp DECERR, rdata 0; read BASE+0x402 -> SLVERR.
REQ-042 Write BASE+0x10 (ROM) or awprot=3'b101 -> bresp SLVERR, subsequent read unchanged.
REQ-043 rready held 0 for 5 cycles -> rvalid/rdata stable, arready 0; reset=0 mid-response -> rvalid=0 next edge, arready=1.
